// File: rtl/reg_scoreboard.sv
// Issue-side hazard scoreboard for a 32x32 register file with one write port
// and asynchronous reads. Tracks destinations owed by long-latency units and
// decides, combinationally, whether the decoded instruction may issue.
module reg_scoreboard #(
  parameter int MAX_LONG = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_use_rs,
  input  logic        issue_use_rt,
  input  logic [4:0]  issue_rd,
  input  logic        issue_writes,
  input  logic        issue_long,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [31:0] pending_out,
  output logic [3:0]  long_count_out,
  output logic        err_out
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_LONG);

  // Bit 0 is kept at zero so r0 can be indexed like any other register.
  logic [31:0] pending;
  logic [3:0]  long_count;
  logic        err;

  logic        wr_eff;
  logic        long_wr;
  logic        haz_raw;
  logic        haz_waw;
  logic        haz_port;
  logic        haz_cap;
  logic        accept_long;
  logic        wb_ok;
  logic        wb_err;
  logic [31:0] pending_nxt;
  logic [3:0]  long_count_nxt;

  // Hazard evaluation from registered state; an in-flight writeback does not
  // bypass to readers, so a matching wb_rd still blocks this cycle.
  always_comb begin
    wr_eff   = issue_writes && (issue_rd != 5'd0);
    long_wr  = wr_eff && issue_long;
    haz_raw  = (issue_use_rs && pending[issue_rs]) ||
               (issue_use_rt && pending[issue_rt]);
    haz_waw  = wr_eff && pending[issue_rd];
    haz_port = wr_eff && !issue_long && wb_valid;
    haz_cap  = long_wr && (long_count == MAX_CNT);
    issue_ready = !(haz_raw || haz_waw || haz_port || haz_cap);
  end

  // Next-state: writeback clears first, then a long accept sets, so a set to
  // the same register in the same cycle wins.
  always_comb begin
    accept_long    = issue_valid && issue_ready && long_wr;
    wb_ok          = wb_valid && (wb_rd != 5'd0) && pending[wb_rd];
    wb_err         = wb_valid && !wb_ok;
    pending_nxt    = pending;
    long_count_nxt = long_count;
    if (wb_ok) begin
      pending_nxt[wb_rd] = 1'b0;
    end
    if (accept_long) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
    case ({accept_long, wb_ok})
      2'b10:   long_count_nxt = long_count + 4'd1;
      2'b01:   long_count_nxt = long_count - 4'd1;
      default: long_count_nxt = long_count;
    endcase
  end

  // State register; reset discards any accept or writeback in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending    <= '0;
      long_count <= '0;
      err        <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      long_count <= long_count_nxt;
      err        <= err || wb_err;
    end
  end

  assign pending_out    = pending;
  assign long_count_out = long_count;
  assign err_out        = err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard with MAX_LONG=4.
module tb_reg_scoreboard;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_use_rs;
  logic        issue_use_rt;
  logic [4:0]  issue_rd;
  logic        issue_writes;
  logic        issue_long;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] pending_out;
  logic [3:0]  long_count_out;
  logic        err_out;

  int tests_run = 0;
  int failures  = 0;

  reg_scoreboard #(.MAX_LONG(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_rs       (issue_rs),
    .issue_rt       (issue_rt),
    .issue_use_rs   (issue_use_rs),
    .issue_use_rt   (issue_use_rt),
    .issue_rd       (issue_rd),
    .issue_writes   (issue_writes),
    .issue_long     (issue_long),
    .issue_ready    (issue_ready),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .pending_out    (pending_out),
    .long_count_out (long_count_out),
    .err_out        (err_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a full input vector (called right after a falling edge).
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic wr, input logic lng, input logic wbv,
                       input logic [4:0] wbr);
    issue_valid  = v;
    issue_rs     = rs;
    issue_rt     = rt;
    issue_use_rs = urs;
    issue_use_rt = urt;
    issue_rd     = rd;
    issue_writes = wr;
    issue_long   = lng;
    wb_valid     = wbv;
    wb_rd        = wbr;
  endtask

  // Advance through the active edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 1, 5'd9);
    tick();
    tests_run++;
    if (pending_out !== 32'h0) begin failures++; $display("FAIL reset_pending: got %h want %h", pending_out, 32'h0); end
    tests_run++;
    if (long_count_out !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", long_count_out); end
    tests_run++;
    if (err_out !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_out); end
    @(negedge clock);
    reset = 1'b0;
    drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 5'd0);
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL short_r5_ready: got %b want 1", issue_ready); end
    tick();
    tests_run++;
    if (pending_out !== 32'h0 || long_count_out !== 4'd0) begin
      failures++; $display("FAIL short_r5_state: pending %h count %0d want 0/0", pending_out, long_count_out);
    end
  endtask

  task automatic test_raw();
    @(negedge clock);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1, 0, 5'd0);
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL long_r8_ready: got %b want 1", issue_ready); end
    tick();
    tests_run++;
    if (pending_out !== 32'h0000_0100 || long_count_out !== 4'd1) begin
      failures++; $display("FAIL long_r8_state: pending %h count %0d want 00000100/1", pending_out, long_count_out);
    end
    @(negedge clock);
    drive(1, 5'd8, 5'd0, 1, 0, 5'd9, 1, 0, 0, 5'd0);
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL raw_rs8_blocked: got %b want 0", issue_ready); end
    @(negedge clock);
    drive(1, 5'd0, 5'd8, 0, 1, 5'd0, 0, 0, 1, 5'd8);
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL raw_in_wb_cycle: got %b want 0", issue_ready); end
    tick();
    @(negedge clock);
    drive(1, 5'd8, 5'd0, 1, 0, 5'd9, 1, 0, 0, 5'd0);
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL raw_after_wb_ready: got %b want 1", issue_ready); end
    tests_run++;
    if (pending_out !== 32'h0 || long_count_out !== 4'd0) begin
      failures++; $display("FAIL raw_after_wb_state: pending %h count %0d want 0/0", pending_out, long_count_out);
    end
    tick();
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin
      @(negedge clock);
      drive(1, 5'd0, 5'd0, 0, 0, 5'(r), 1, 1, 0, 5'd0);
      tick();
    end
    tests_run++;
    if (pending_out !== 32'h0000_001E || long_count_out !== 4'd4) begin
      failures++; $display("FAIL cap_fill: pending %h count %0d want 0000001e/4", pending_out, long_count_out);
    end
    @(negedge clock);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 0, 5'd0);
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL cap_full_r9: got %b want 0", issue_ready); end
    drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 1, 5'd2);
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL cap_full_with_wb: got %b want 0", issue_ready); end
    drive(1, 5'd0, 5'd0, 0, 0, 5'd10, 1, 0, 1, 5'd2);
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL port_conflict_r10: got %b want 0", issue_ready); end
    tick();
    tests_run++;
    if (pending_out !== 32'h0000_001A || long_count_out !== 4'd3) begin
      failures++; $display("FAIL cap_after_wb2: pending %h count %0d want 0000001a/3", pending_out, long_count_out);
    end
    @(negedge clock);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 0, 5'd0);
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL cap_r9_accept: got %b want 1", issue_ready); end
    tick();
    tests_run++;
    if (pending_out !== 32'h0000_021A || long_count_out !== 4'd4) begin
      failures++; $display("FAIL cap_r9_state: pending %h count %0d want 0000021a/4", pending_out, long_count_out);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      case (k)
        0: drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'd1);
        1: drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'd3);
        2: drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'd4);
        default: drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'd9);
      endcase
      tick();
    end
    tests_run++;
    if (pending_out !== 32'h0 || long_count_out !== 4'd0 || err_out !== 1'b0) begin
      failures++; $display("FAIL cap_drain: pending %h count %0d err %b want 0/0/0", pending_out, long_count_out, err_out);
    end
  endtask

  task automatic test_waw_r0();
    @(negedge clock);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd6, 1, 1, 0, 5'd0);
    tick();
    @(negedge clock);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd6, 1, 0, 0, 5'd0);
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL waw_short_r6: got %b want 0", issue_ready); end
    drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 5'd0);
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL long_r0_ready: got %b want 1", issue_ready); end
    tick();
    tests_run++;
    if (pending_out !== 32'h0000_0040 || long_count_out !== 4'd1) begin
      failures++; $display("FAIL long_r0_state: pending %h count %0d want 00000040/1", pending_out, long_count_out);
    end
    // Short write to r0 during writeback and an unused rt naming r6 are not hazards.
    @(negedge clock);
    drive(1, 5'd0, 5'd6, 1, 0, 5'd0, 1, 0, 1, 5'd6);
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL r0_short_unused_rt: got %b want 1", issue_ready); end
    tick();
    tests_run++;
    if (pending_out !== 32'h0 || long_count_out !== 4'd0) begin
      failures++; $display("FAIL waw_drain: pending %h count %0d want 0/0", pending_out, long_count_out);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clock);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 1, 0, 5'd0);
    tick();
    @(negedge clock);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 1, 5'd3);
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL simul_ready: got %b want 1", issue_ready); end
    tick();
    tests_run++;
    if (pending_out !== 32'h0000_0080 || long_count_out !== 4'd1 || err_out !== 1'b0) begin
      failures++; $display("FAIL simul_state: pending %h count %0d err %b want 00000080/1/0", pending_out, long_count_out, err_out);
    end
    @(negedge clock);
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'd7);
    tick();
  endtask

  task automatic test_err_reset();
    @(negedge clock);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd12, 1, 1, 0, 5'd0);
    tick();
    tests_run++;
    if (pending_out !== 32'h0000_1000 || long_count_out !== 4'd1) begin
      failures++; $display("FAIL err_r12_state: pending %h count %0d want 00001000/1", pending_out, long_count_out);
    end
    @(negedge clock);
    reset = 1'b1;
    drive(1, 5'd0, 5'd0, 0, 0, 5'd13, 1, 1, 0, 5'd0);
    tick();
    tests_run++;
    if (pending_out !== 32'h0 || long_count_out !== 4'd0) begin
      failures++; $display("FAIL reset_overrides_accept: pending %h count %0d want 0/0", pending_out, long_count_out);
    end
    @(negedge clock);
    reset = 1'b0;
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'd12);
    tick();
    tests_run++;
    if (err_out !== 1'b1 || long_count_out !== 4'd0 || pending_out !== 32'h0) begin
      failures++; $display("FAIL stale_wb_err: err %b count %0d pending %h want 1/0/0", err_out, long_count_out, pending_out);
    end
    @(negedge clock);
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'd0);
    tick();
    tests_run++;
    if (err_out !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", err_out); end
    @(negedge clock);
    reset = 1'b1;
    tick();
    tests_run++;
    if (err_out !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b want 0", err_out); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raw();
    test_capacity();
    test_waw_r0();
    test_simultaneous();
    test_err_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
